fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the CPU core FSM. It owns the architectural fetch PC and issues word requests to instruction memory over a req/ack handshake. It presents each fetched instruction, its PC and a fault flag to the core through a one-entry valid/ready output register. Branch and jump redirects from the execute stage retarget it, including while a memory request is in flight.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests over req/ack,
// and hands fetched words to the core through a one-entry valid/ready register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    FULL,
    FLUSH,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        tfault_q, tfault_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] entry_pc_q, entry_pc_d;
  logic        fault_q, fault_d;

  logic        take;
  logic [31:0] take_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      target_q   <= 32'h0;
      tfault_q   <= 1'b0;
      instr_q    <= 32'h0;
      entry_pc_q <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      tfault_q   <= tfault_d;
      instr_q    <= instr_d;
      entry_pc_q <= entry_pc_d;
      fault_q    <= fault_d;
    end
  end

  // Every retarget (redirect or deferred target) funnels through take/take_pc.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    target_d   = target_q;
    tfault_d   = tfault_q;
    instr_d    = instr_q;
    entry_pc_d = entry_pc_q;
    fault_d    = fault_q;
    take       = 1'b0;
    take_pc    = redirect_pc;

    case (state_q)
      BOOT: state_d = REQ;

      REQ: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            take = 1'b1;
          end else begin
            target_d = redirect_pc;
            tfault_d = (redirect_pc[1:0] != 2'b00);
            state_d  = FLUSH;
          end
        end else if (imem_ack) begin
          instr_d    = imem_err ? 32'h0 : imem_rdata;
          entry_pc_d = pc_q;
          fault_d    = imem_err;
          if (!imem_err) pc_d = pc_q + 32'd4;
          state_d = FULL;
        end
      end

      FLUSH: begin
        if (imem_ack) begin
          take = 1'b1;
          if (!redirect_valid) take_pc = target_q;
        end else if (redirect_valid) begin
          target_d = redirect_pc;
          tfault_d = (redirect_pc[1:0] != 2'b00);
        end
      end

      FULL: begin
        if (redirect_valid) begin
          take = 1'b1;
        end else if (fetch_ready) begin
          state_d = fault_q ? HALT : REQ;
        end
      end

      HALT: begin
        if (redirect_valid) take = 1'b1;
      end

      default: state_d = BOOT;
    endcase

    // A misaligned target never reaches memory; it becomes a fault entry instead.
    if (take) begin
      if (take_pc[1:0] == 2'b00) begin
        pc_d    = take_pc;
        state_d = REQ;
      end else begin
        instr_d    = 32'h0;
        entry_pc_d = take_pc;
        fault_d    = 1'b1;
        state_d    = FULL;
      end
    end
  end

  assign imem_req    = (state_q == REQ) || (state_q == FLUSH);
  assign imem_addr   = pc_q;
  assign fetch_valid = (state_q == FULL);
  assign fetch_instr = instr_q;
  assign fetch_pc    = entry_pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wait-state memory, a transaction-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0000_0100;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  int          mem_wait = 0;
  int          mem_cnt;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_fault    (fetch_fault)
  );

  // Memory acks after mem_wait cycles of a held request; word = address ^ KEY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_cnt <= 0;
    else if (!imem_req || imem_ack) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  assign imem_ack   = imem_req && (mem_cnt >= mem_wait);
  assign imem_rdata = imem_addr ^ KEY;
  assign imem_err   = imem_ack && err_en && (imem_addr == err_addr);

  // Reference model: a fetch is outstanding whenever nothing is held, halted or booting.
  typedef struct packed {
    logic        booting;
    logic        halted;
    logic        slot_valid;
    logic        pending;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic        s_fault;
  } model_t;

  model_t m;

  function automatic model_t model_take(model_t cur, logic [31:0] a);
    model_t n = cur;
    n.slot_valid = 1'b0;
    n.halted     = 1'b0;
    n.pending    = 1'b0;
    if (a[1:0] == 2'b00) begin
      n.pc = a;
    end else begin
      n.slot_valid = 1'b1;
      n.s_instr    = 32'h0;
      n.s_pc       = a;
      n.s_fault    = 1'b1;
    end
    return n;
  endfunction

  function automatic model_t model_step(model_t cur, logic ack, logic [31:0] rdata,
                                        logic err, logic rv, logic [31:0] rpc, logic rdy);
    model_t n = cur;
    if (cur.booting) begin
      n.booting = 1'b0;
    end else if (!cur.slot_valid && !cur.halted) begin
      if (ack) begin
        if (rv) n = model_take(cur, rpc);
        else if (cur.pending) n = model_take(cur, cur.target);
        else begin
          n.slot_valid = 1'b1;
          n.s_pc       = cur.pc;
          n.s_fault    = err;
          n.s_instr    = err ? 32'h0 : rdata;
          if (!err) n.pc = cur.pc + 32'd4;
        end
      end else if (rv) begin
        n.pending = 1'b1;
        n.target  = rpc;
      end
    end else begin
      if (rv) n = model_take(cur, rpc);
      else if (cur.slot_valid && rdy) begin
        n.slot_valid = 1'b0;
        n.halted     = cur.s_fault;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m         <= '0;
      m.booting <= 1'b1;
      m.pc      <= RST;
    end else begin
      m <= model_step(m, imem_ack, imem_rdata, imem_err, redirect_valid, redirect_pc, fetch_ready);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checkOutput("model req", {31'h0, imem_req}, {31'h0, !m.booting && !m.slot_valid && !m.halted});
      checkOutput("model addr", imem_addr, m.pc);
      checkOutput("model valid", {31'h0, fetch_valid}, {31'h0, m.slot_valid});
      if (m.slot_valid) begin
        checkOutput("model instr", fetch_instr, m.s_instr);
        checkOutput("model pc", fetch_pc, m.s_pc);
        checkOutput("model fault", {31'h0, fetch_fault}, {31'h0, m.s_fault});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    fetch_ready    = rdy;
  endtask

  task automatic waitValid(input int limit);
    int n = 0;
    while (!fetch_valid && n < limit) begin
      tick();
      n++;
    end
    if (!fetch_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait valid: got timeout expected entry within %0d cycles", limit);
    end
  endtask

  task automatic checkEntry(input string name, input logic [31:0] pc, input logic [31:0] instr,
                            input logic fault);
    checkOutput({name, " valid"}, {31'h0, fetch_valid}, 32'h1);
    checkOutput({name, " pc"}, fetch_pc, pc);
    checkOutput({name, " instr"}, fetch_instr, instr);
    checkOutput({name, " fault"}, {31'h0, fetch_fault}, {31'h0, fault});
  endtask

  task automatic checkReq(input string name, input logic req, input logic [31:0] addr);
    checkOutput({name, " req"}, {31'h0, imem_req}, {31'h0, req});
    if (req) checkOutput({name, " addr"}, imem_addr, addr);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req", {31'h0, imem_req}, 32'h0);
    checkOutput("reset addr", imem_addr, 32'h100);
    checkOutput("reset valid", {31'h0, fetch_valid}, 32'h0);
    checkOutput("reset instr", fetch_instr, 32'h0);
    checkOutput("reset pc", fetch_pc, 32'h0);
    checkOutput("reset fault", {31'h0, fetch_fault}, 32'h0);
    #2 reset_n = 1'b1;

    // Zero-wait streaming from reset
    tick();
    checkReq("boot", 1'b1, 32'h100);
    tick();
    checkEntry("e100", 32'h100, 32'h100 ^ KEY, 1'b0);
    checkReq("e100", 1'b0, 32'h0);
    tick();
    checkReq("r104", 1'b1, 32'h104);
    fetch_ready = 1'b0;
    tick();
    checkEntry("e104", 32'h104, 32'h104 ^ KEY, 1'b0);

    // Back-pressure holds the slot
    for (int i = 0; i < 5; i++) begin
      tick();
      checkEntry("stall", 32'h104, 32'h104 ^ KEY, 1'b0);
      checkReq("stall", 1'b0, 32'h0);
    end
    fetch_ready = 1'b1;
    tick();
    checkReq("r108", 1'b1, 32'h108);
    tick();
    checkEntry("e108", 32'h108, 32'h108 ^ KEY, 1'b0);

    // Redirect while a 3-wait request is outstanding
    mem_wait = 3;
    tick();
    checkReq("r10c", 1'b1, 32'h10C);
    applyStimulus(1'b1, 32'h200, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkReq("flush1", 1'b1, 32'h10C);
    tick();
    checkReq("flush2", 1'b1, 32'h10C);
    tick();
    checkReq("flush3", 1'b1, 32'h10C);
    tick();
    checkReq("r200", 1'b1, 32'h200);
    checkOutput("r200 valid", {31'h0, fetch_valid}, 32'h0);
    fetch_ready = 1'b0;
    waitValid(20);
    checkEntry("e200", 32'h200, 32'h200 ^ KEY, 1'b0);

    // Access fault, halt, redirect out
    mem_wait = 0;
    err_en   = 1'b1;
    err_addr = 32'h10;
    applyStimulus(1'b1, 32'h10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkReq("r10", 1'b1, 32'h10);
    tick();
    checkEntry("err10", 32'h10, 32'h0, 1'b1);
    fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkReq("halt", 1'b0, 32'h0);
      checkOutput("halt valid", {31'h0, fetch_valid}, 32'h0);
    end
    err_en = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkReq("r40", 1'b1, 32'h40);
    tick();
    checkEntry("e40", 32'h40, 32'h40 ^ KEY, 1'b0);

    // Misaligned redirect replaces a full slot
    applyStimulus(1'b1, 32'h202, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkEntry("mis202", 32'h202, 32'h0, 1'b1);
    checkReq("mis202", 1'b0, 32'h0);
    fetch_ready = 1'b1;
    tick();
    checkReq("halt202", 1'b0, 32'h0);
    checkOutput("halt202 valid", {31'h0, fetch_valid}, 32'h0);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkReq("rtop", 1'b1, 32'hFFFF_FFFC);
    tick();
    checkEntry("etop", 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY, 1'b0);
    checkOutput("wrap addr", imem_addr, 32'h0);

    // Latest redirect during a flush wins, and a misaligned target faults
    mem_wait = 2;
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    checkReq("r0", 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h300, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h301, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkReq("flush301", 1'b1, 32'h0);
    tick();
    checkEntry("mis301", 32'h301, 32'h0, 1'b1);

    // Redirect coinciding with a zero-wait ack discards the returned word
    mem_wait = 0;
    applyStimulus(1'b1, 32'h500, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h600, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkReq("r600", 1'b1, 32'h600);
    checkOutput("r600 valid", {31'h0, fetch_valid}, 32'h0);
    tick();
    checkEntry("e600", 32'h600, 32'h600 ^ KEY, 1'b0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
